// File: rtl/dac_channel_scheduler_if.sv
// Handshake between the channel scheduler and the DAC70004 serial frame writer.
interface dac_channel_scheduler_if;
    logic        DAC_WE;
    logic [31:0] DAC_DATA;
    logic        DAC_BUSY;

    modport master (output DAC_WE, output DAC_DATA, input DAC_BUSY);
    modport slave  (input DAC_WE, input DAC_DATA, output DAC_BUSY);
endinterface

// File: rtl/dac_channel_scheduler.sv
// 4-channel shadow bank that round-robins dirty channels into DAC70004 write-and-update frames.
// Define AUTO_REFRESH_EN to mark every channel dirty once per REFRESH_PERIOD cycles.
module dac_channel_scheduler #(
    parameter logic [3:0]  CMD_WRUPD      = 4'h3,
    parameter bit          INIT_SEND      = 1'b1,
    parameter logic [31:0] INIT_WORD      = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT    = 8
`ifdef AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH_PERIOD = 5_000_000
`endif
) (
    input  logic                           CLK_50M,
    input  logic                           DLL_LOCKED,
    input  logic                           CH_WE,
    input  logic [1:0]                     CH_ADDR,
    input  logic [15:0]                    CH_DATA,
    input  logic                           UPDATE_ALL,
    dac_channel_scheduler_if.master        dac,
    output logic                           CTRL_IDLE,
    output logic [15:0]                    FRAME_CNT,
    output logic                           TIMEOUT_ERR
);
    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

    state_e      state_q;
    logic [15:0] shadow_q [4];
    logic [3:0]  dirty_q;
    logic [1:0]  rr_ptr_q;
    logic [1:0]  ch_q;
    logic        init_pending_q;
    logic        is_init_q;
    logic [7:0]  timer_q;
    logic        dac_we_q;
    logic [31:0] dac_data_q;

    logic        busy;
    logic        sel_found;
    logic [1:0]  sel_ch;
    logic        go_init;
    logic        go_ch;
    logic        ack_timeout;
    logic        refresh_hit;
    logic [3:0]  dirty_set;
    logic [3:0]  dirty_clr;
    logic [3:0]  dirty_rearm;

    assign busy         = dac.DAC_BUSY;
    assign dac.DAC_WE   = dac_we_q;
    assign dac.DAC_DATA = dac_data_q;

`ifdef AUTO_REFRESH_EN
    logic [22:0] refresh_q;

    assign refresh_hit = (refresh_q == 23'(REFRESH_PERIOD - 1));

    always_ff @(posedge CLK_50M) begin
        if (!DLL_LOCKED || refresh_hit) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + 23'd1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    always_comb begin
        // Walk offsets high to low so the nearest dirty channel after rr_ptr wins.
        sel_found = 1'b0;
        sel_ch    = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (dirty_q[rr_ptr_q + 2'(i)]) begin
                sel_found = 1'b1;
                sel_ch    = rr_ptr_q + 2'(i);
            end
        end

        go_init     = (state_q == StIdle) && init_pending_q && !busy;
        go_ch       = (state_q == StIdle) && !init_pending_q && sel_found && !busy;
        ack_timeout = (state_q == StWaitAck) && !busy && (timer_q == 8'(ACK_TIMEOUT - 1));

        dirty_set = 4'b0;
        if (CH_WE) begin
            dirty_set = dirty_set | (4'b1 << CH_ADDR);
        end
        if (UPDATE_ALL || refresh_hit) begin
            dirty_set = 4'b1111;
        end
        dirty_clr   = go_ch ? (4'b1 << sel_ch) : 4'b0;
        dirty_rearm = (ack_timeout && !is_init_q) ? (4'b1 << ch_q) : 4'b0;
    end

    always_ff @(posedge CLK_50M) begin
        if (!DLL_LOCKED) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
            dirty_q        <= '0;
            rr_ptr_q       <= '0;
            ch_q           <= '0;
            init_pending_q <= INIT_SEND;
            is_init_q      <= 1'b0;
            timer_q        <= '0;
            dac_we_q       <= 1'b0;
            dac_data_q     <= '0;
            CTRL_IDLE      <= 1'b0;
            FRAME_CNT      <= '0;
            TIMEOUT_ERR    <= 1'b0;
            state_q        <= StIdle;
        end else begin
            if (CH_WE) begin
                shadow_q[CH_ADDR] <= CH_DATA;
            end
            // Sets are OR'd in last so a same-cycle write keeps the channel dirty.
            dirty_q   <= (dirty_q & ~dirty_clr) | dirty_set | dirty_rearm;
            CTRL_IDLE <= (state_q == StIdle) && !init_pending_q && (dirty_q == 4'b0);

            case (state_q)
                StIdle: begin
                    dac_we_q <= 1'b0;
                    if (go_init) begin
                        dac_we_q       <= 1'b1;
                        dac_data_q     <= INIT_WORD;
                        init_pending_q <= 1'b0;
                        is_init_q      <= 1'b1;
                        state_q        <= StIssue;
                    end else if (go_ch) begin
                        dac_we_q   <= 1'b1;
                        dac_data_q <= {4'h0, CMD_WRUPD, 2'b00, sel_ch, shadow_q[sel_ch], 4'h0};
                        is_init_q  <= 1'b0;
                        ch_q       <= sel_ch;
                        rr_ptr_q   <= sel_ch + 2'd1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    dac_we_q <= 1'b0;
                    timer_q  <= '0;
                    state_q  <= StWaitAck;
                end
                StWaitAck: begin
                    if (busy) begin
                        state_q <= StWaitDone;
                    end else if (ack_timeout) begin
                        TIMEOUT_ERR <= 1'b1;
                        if (is_init_q) begin
                            init_pending_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StWaitDone: begin
                    if (!busy) begin
                        FRAME_CNT <= FRAME_CNT + 16'd1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    dac_we_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Randomized bench for dac_channel_scheduler: a writer model on the DAC handshake and a
// round-robin frame model predict every frame, FRAME_CNT and the status flags.
module tb_dac_channel_scheduler;
    localparam logic [31:0] InitWord = 32'h0A00_0001;

    logic        CLK_50M;
    logic        DLL_LOCKED;
    logic        CH_WE;
    logic [1:0]  CH_ADDR;
    logic [15:0] CH_DATA;
    logic        UPDATE_ALL;
    logic        CTRL_IDLE;
    logic [15:0] FRAME_CNT;
    logic        TIMEOUT_ERR;

    dac_channel_scheduler_if dac ();

    int checks   = 0;
    int failures = 0;

    dac_channel_scheduler #(
        .CMD_WRUPD      (4'h3),
        .INIT_SEND      (1'b1),
        .INIT_WORD      (InitWord),
        .ACK_TIMEOUT    (8)
`ifdef AUTO_REFRESH_EN
        ,
        .REFRESH_PERIOD (100)
`endif
    ) dut (
        .CLK_50M     (CLK_50M),
        .DLL_LOCKED  (DLL_LOCKED),
        .CH_WE       (CH_WE),
        .CH_ADDR     (CH_ADDR),
        .CH_DATA     (CH_DATA),
        .UPDATE_ALL  (UPDATE_ALL),
        .dac         (dac.master),
        .CTRL_IDLE   (CTRL_IDLE),
        .FRAME_CNT   (FRAME_CNT),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial begin
        CLK_50M = 1'b0;
        forever #10 CLK_50M = ~CLK_50M;
    end

    // Serial writer: BUSY rises the cycle after WE and stays up for a random frame time.
    int unsigned ft_lo = 3;
    int unsigned ft_hi = 10;
    int          frame_left = 0;
    bit          writer_dead = 1'b0;
    bit          hold_busy = 1'b0;
    logic [31:0] we_log [$];

    always @(posedge CLK_50M) begin
        if (dac.DAC_WE === 1'b1) begin
            we_log.push_back(dac.DAC_DATA);
            if (!writer_dead) frame_left <= int'($urandom_range(ft_hi, ft_lo));
        end else if (frame_left > 0) begin
            frame_left <= frame_left - 1;
        end
    end

    assign dac.DAC_BUSY = hold_busy | (frame_left > 0);

    // Reference model: shadow values, dirty set, round-robin pointer, completed frame count.
    logic [15:0] m_shadow [4];
    bit   [3:0]  m_dirty;
    int          m_ptr;
    logic [15:0] m_fcnt;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] exp_frame(input logic [1:0] ch, input logic [15:0] d);
        return {4'h0, 4'h3, 2'b00, ch, d, 4'h0};
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 16'h0;
        m_dirty = 4'b0;
        m_ptr   = 0;
        m_fcnt  = 16'd1;
        exp_q.delete();
        exp_q.push_back(InitWord);
    endfunction

    function automatic void m_drain();
        while (m_dirty != 4'b0) begin
            for (int off = 0; off < 4; off++) begin
                int c = (m_ptr + off) % 4;
                if (m_dirty[c]) begin
                    exp_q.push_back(exp_frame(2'(c), m_shadow[c]));
                    m_dirty[c] = 1'b0;
                    m_ptr      = (c + 1) % 4;
                    m_fcnt     = m_fcnt + 16'd1;
                    break;
                end
            end
        end
    endfunction

    task automatic ch_write(input logic [1:0] ch, input logic [15:0] d);
        CH_WE   = 1'b1;
        CH_ADDR = ch;
        CH_DATA = d;
        @(negedge CLK_50M);
        CH_WE = 1'b0;
        m_shadow[ch] = d;
        m_dirty[ch]  = 1'b1;
    endtask

    task automatic pulse_update_all();
        UPDATE_ALL = 1'b1;
        @(negedge CLK_50M);
        UPDATE_ALL = 1'b0;
        m_dirty = 4'b1111;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        repeat (4) @(negedge CLK_50M);
        while (!(CTRL_IDLE === 1'b1 && dac.DAC_BUSY === 1'b0) && n < 3000) begin
            @(negedge CLK_50M);
            n++;
        end
        ok = (n < 3000);
    endtask

    task automatic test_reset();
        DLL_LOCKED = 1'b0;
        CH_WE = 1'b0; CH_ADDR = 2'd0; CH_DATA = 16'h0; UPDATE_ALL = 1'b0;
        repeat (3) @(negedge CLK_50M);
        checks += 5;
        if (dac.DAC_WE !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", dac.DAC_WE); end
        if (dac.DAC_DATA !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", dac.DAC_DATA); end
        if (CTRL_IDLE !== 1'b0) begin failures++; $display("FAIL reset_idle: got %b want 0", CTRL_IDLE); end
        if (FRAME_CNT !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %h want 0", FRAME_CNT); end
        if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", TIMEOUT_ERR); end
    endtask

    task automatic test_init();
        bit ok;
        we_log.delete();
        m_reset();
        DLL_LOCKED = 1'b1;
        wait_idle(ok);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL init_idle: got busy want idle"); end
        if (we_log.size() !== 1) begin failures++; $display("FAIL init_frames: got %0d want 1", we_log.size()); end
        else if (we_log[0] !== InitWord) begin failures++; $display("FAIL init_word: got %h want %h", we_log[0], InitWord); end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL init_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
        if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL init_err: got %b want 0", TIMEOUT_ERR); end
    endtask

    task automatic test_single();
        bit ok;
        we_log.delete(); exp_q.delete();
        ch_write(2'd2, 16'hBEEF);
        m_drain();
        wait_idle(ok);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL single_idle: got busy want idle"); end
        if (we_log.size() !== 1) begin failures++; $display("FAIL single_frames: got %0d want 1", we_log.size()); end
        else if (we_log[0] !== 32'h032B_EEF0) begin failures++; $display("FAIL single_data: got %h want 032beef0", we_log[0]); end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL single_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
        if (CTRL_IDLE !== 1'b1) begin failures++; $display("FAIL single_ctrl_idle: got %b want 1", CTRL_IDLE); end
    endtask

    task automatic test_update_all();
        bit ok;
        logic [1:0] order [4];
        order = '{2'd1, 2'd2, 2'd3, 2'd0};
        ch_write(2'd0, 16'h1234);
        m_drain();
        wait_idle(ok);
        we_log.delete(); exp_q.delete();
        pulse_update_all();
        m_drain();
        wait_idle(ok);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL upd_idle: got busy want idle"); end
        if (we_log.size() !== 4) begin failures++; $display("FAIL upd_frames: got %0d want 4", we_log.size()); end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL upd_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
        for (int i = 0; i < 4 && i < we_log.size(); i++) begin
            checks += 2;
            if (we_log[i][21:20] !== order[i]) begin
                failures++; $display("FAIL upd_order[%0d]: got ch%0d want ch%0d", i, we_log[i][21:20], order[i]);
            end
            if (we_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL upd_data[%0d]: got %h want %h", i, we_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int r = 0; r < 8; r++) begin
            we_log.delete(); exp_q.delete();
            hold_busy = 1'b1;
            @(negedge CLK_50M);
            for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
                if ($urandom_range(4, 0) == 0) pulse_update_all();
                else ch_write(2'($urandom_range(3, 0)), 16'($urandom));
                if ($urandom_range(1, 0) == 1) @(negedge CLK_50M);
            end
            hold_busy = 1'b0;
            m_drain();
            wait_idle(ok);
            checks += 3;
            if (!ok) begin failures++; $display("FAIL rnd%0d_idle: got busy want idle", r); end
            if (we_log.size() !== exp_q.size()) begin
                failures++; $display("FAIL rnd%0d_frames: got %0d want %0d", r, we_log.size(), exp_q.size());
            end
            if (FRAME_CNT !== m_fcnt) begin
                failures++; $display("FAIL rnd%0d_cnt: got %0d want %0d", r, FRAME_CNT, m_fcnt);
            end
            for (int i = 0; i < exp_q.size() && i < we_log.size(); i++) begin
                checks++;
                if (we_log[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", r, i, we_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        we_log.delete(); exp_q.delete();
        ch_write(2'd0, 16'hAAAA);
        m_drain();
        while (dac.DAC_BUSY !== 1'b1 && n < 50) begin @(negedge CLK_50M); n++; end
        @(negedge CLK_50M);
        ch_write(2'd0, 16'h5555);
        m_drain();
        wait_idle(ok);
        checks += 4;
        if (n >= 50 || !ok) begin failures++; $display("FAIL b2b_handshake: got stall want completion"); end
        if (we_log.size() !== 2) begin failures++; $display("FAIL b2b_frames: got %0d want 2", we_log.size()); end
        else if (we_log[1] !== exp_frame(2'd0, 16'h5555)) begin
            failures++; $display("FAIL b2b_resend: got %h want %h", we_log[1], exp_frame(2'd0, 16'h5555));
        end
        if (we_log.size() > 0 && we_log[0] !== exp_frame(2'd0, 16'hAAAA)) begin
            failures++; $display("FAIL b2b_first: got %h want %h", we_log[0], exp_frame(2'd0, 16'hAAAA));
        end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL b2b_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        logic [31:0] want;
        want = exp_frame(2'd1, 16'hC0DE);
        we_log.delete(); exp_q.delete();
        writer_dead = 1'b1;
        ch_write(2'd1, 16'hC0DE);
        m_drain();
        while (dac.DAC_WE !== 1'b1 && n < 20) begin @(negedge CLK_50M); n++; end
        checks++;
        if (dac.DAC_DATA !== want) begin failures++; $display("FAIL to_first: got %h want %h", dac.DAC_DATA, want); end
        n = 0;
        while (TIMEOUT_ERR !== 1'b1 && n < 40) begin @(negedge CLK_50M); n++; end
        checks++;
        if (n !== 9) begin failures++; $display("FAIL to_latency: got %0d cycles want 9", n); end
        n = 0;
        while (dac.DAC_WE !== 1'b1 && n < 5) begin @(negedge CLK_50M); n++; end
        writer_dead = 1'b0;
        checks += 2;
        if (n >= 5) begin failures++; $display("FAIL to_retry: got no DAC_WE want retry"); end
        if (dac.DAC_DATA !== want) begin failures++; $display("FAIL to_retry_data: got %h want %h", dac.DAC_DATA, want); end
        wait_idle(ok);
        checks += 3;
        if (!ok || we_log.size() !== 2) begin
            failures++; $display("FAIL to_frames: got %0d want 2", we_log.size());
        end
        if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", TIMEOUT_ERR); end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL to_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        ch_write(2'd3, 16'h7777);
        while (dac.DAC_BUSY !== 1'b1 && n < 50) begin @(negedge CLK_50M); n++; end
        @(negedge CLK_50M);
        DLL_LOCKED = 1'b0;
        @(negedge CLK_50M);
        checks += 5;
        if (dac.DAC_WE !== 1'b0) begin failures++; $display("FAIL mid_we: got %b want 0", dac.DAC_WE); end
        if (dac.DAC_DATA !== 32'h0) begin failures++; $display("FAIL mid_data: got %h want 0", dac.DAC_DATA); end
        if (CTRL_IDLE !== 1'b0) begin failures++; $display("FAIL mid_idle: got %b want 0", CTRL_IDLE); end
        if (FRAME_CNT !== 16'h0) begin failures++; $display("FAIL mid_cnt: got %0d want 0", FRAME_CNT); end
        if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL mid_err: got %b want 0", TIMEOUT_ERR); end
        @(negedge CLK_50M);
        we_log.delete();
        m_reset();
        DLL_LOCKED = 1'b1;
        wait_idle(ok);
        checks += 2;
        if (!ok || we_log.size() !== 1 || we_log[0] !== InitWord) begin
            failures++; $display("FAIL mid_reinit: got %0d frames want 1 init frame", we_log.size());
        end
        if (FRAME_CNT !== m_fcnt) begin failures++; $display("FAIL mid_reinit_cnt: got %0d want %0d", FRAME_CNT, m_fcnt); end
    endtask

    task automatic test_refresh();
        ft_lo = 4; ft_hi = 4;
        DLL_LOCKED = 1'b0;
        repeat (2) @(negedge CLK_50M);
        we_log.delete();
        DLL_LOCKED = 1'b1;
        repeat (1040) @(negedge CLK_50M);
        checks += 2;
        if (we_log.size() !== 41) begin failures++; $display("FAIL refresh_frames: got %0d want 41", we_log.size()); end
        if (FRAME_CNT !== 16'd41) begin failures++; $display("FAIL refresh_cnt: got %0d want 41", FRAME_CNT); end
        for (int i = 1; i < 41 && i < we_log.size(); i++) begin
            checks++;
            if (we_log[i] !== exp_frame(2'((i - 1) % 4), 16'h0)) begin
                failures++; $display("FAIL refresh_data[%0d]: got %h want %h", i, we_log[i],
                                     exp_frame(2'((i - 1) % 4), 16'h0));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
`ifdef AUTO_REFRESH_EN
        test_refresh();
`else
        test_single();
        test_update_all();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
